// File: rtl/updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter.
// Holds the direction encoding, the operation encoding used by the
// per-edge priority decode, the default-modulus constant function and
// the parallel-load clamp function.
package updown_counter_pkg;

  // Direction encoding on the updown input and the dir_q output.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest counter supported; helper functions work at MAX_WIDTH+1 bits
  // so that a modulus of 2**32 is still representable.
  localparam int unsigned MAX_WIDTH = 32;

  typedef logic [MAX_WIDTH:0] wide_t;

  // Operation selected on a clock edge once clear is inactive.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } op_e;

  // Full binary range of a WIDTH-bit counter: 2**width.
  function automatic longint unsigned default_modulus(input int unsigned width);
    return 64'd1 << width;
  endfunction

  // Parallel-load value limited to the top of the count range.
  function automatic wide_t clamp_load(input wide_t value, input wide_t modulus);
    wide_t result;
    if (value >= modulus) begin
      result = modulus - 33'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage : updown_counter_pkg

// File: rtl/updown_next_state.sv
// Combinational step logic of the up/down counter.
// Given the present count and the direction it returns the count after
// one counting step and flags whether that step met a range boundary.
// Build option: define COUNTER_SATURATE_EN to hold at the boundaries
// instead of wrapping around.
module updown_next_state
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH   = 3,
  parameter longint unsigned MODULUS = default_modulus(WIDTH)
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             updown_i,
  output logic [WIDTH-1:0] next_o,
  output logic             hit_o
);

  // Highest legal count, carried at WIDTH+1 bits like every intermediate.
  localparam logic [WIDTH:0] TOP_W = (WIDTH+1)'(MODULUS - 64'd1);

  logic [WIDTH:0] count_ext_s;
  logic [WIDTH:0] next_ext_s;
  logic           next_msb_unused_s;

  // Step by one in the requested direction, handling both range ends.
  always_comb begin
    count_ext_s = {1'b0, count_i};
    next_ext_s  = count_ext_s;
    hit_o       = 1'b0;
    case (updown_i)
      DIR_UP: begin
        if (count_ext_s >= TOP_W) begin
          hit_o = 1'b1;
`ifdef COUNTER_SATURATE_EN
          next_ext_s = count_ext_s;
`else
          next_ext_s = {(WIDTH+1){1'b0}};
`endif
        end else begin
          next_ext_s = count_ext_s + {{WIDTH{1'b0}}, 1'b1};
        end
      end
      DIR_DOWN: begin
        if (count_ext_s == {(WIDTH+1){1'b0}}) begin
          hit_o = 1'b1;
`ifdef COUNTER_SATURATE_EN
          next_ext_s = count_ext_s;
`else
          next_ext_s = TOP_W;
`endif
        end else begin
          next_ext_s = count_ext_s - {{WIDTH{1'b0}}, 1'b1};
        end
      end
      default: begin
        next_ext_s = count_ext_s;
        hit_o      = 1'b0;
      end
    endcase
    next_o = next_ext_s[WIDTH-1:0];
  end

  // The extra bit never sets because every step stays within 0..MODULUS-1.
  assign next_msb_unused_s = next_ext_s[WIDTH];

endmodule : updown_next_state

// File: rtl/updown_counter_n.sv
// Modulo-N up/down counter with parallel load, boundary pulse and
// registered direction.
// Per edge priority: clear (async, active-low), then load, then enable.
// Build option: define COUNTER_SATURATE_EN to saturate at the range ends
// instead of wrapping (handled inside updown_next_state).
module updown_counter_n
  import updown_counter_pkg::*;
#(
  parameter int              WIDTH   = 3,
  parameter longint unsigned MODULUS = default_modulus(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             dir_q
);

  localparam wide_t MODULUS_W = wide_t'(MODULUS);

  logic [WIDTH-1:0]           count_q;
  logic [WIDTH-1:0]           count_d;
  logic                       carry_q;
  logic                       carry_d;
  logic                       direction_q;
  logic                       direction_d;

  logic [WIDTH-1:0]           step_next_s;
  logic                       step_hit_s;
  op_e                        op_s;

  wide_t                      load_ext_s;
  wide_t                      clamp_wide_s;
  logic [WIDTH-1:0]           load_clamped_s;
  logic [MAX_WIDTH-WIDTH:0]   clamp_hi_unused_s;

  // Counting step (wrap or saturate) computed from the present count.
  updown_next_state #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next_state (
    .count_i  (count_q),
    .updown_i (updown),
    .next_o   (step_next_s),
    .hit_o    (step_hit_s)
  );

  // Widen the load value, clamp it to MODULUS-1 and narrow it back.
  always_comb begin
    load_ext_s        = {{(MAX_WIDTH+1-WIDTH){1'b0}}, load_value};
    clamp_wide_s      = clamp_load(load_ext_s, MODULUS_W);
    load_clamped_s    = clamp_wide_s[WIDTH-1:0];
    clamp_hi_unused_s = clamp_wide_s[MAX_WIDTH:WIDTH];
  end

  // Resolve load-over-enable priority into a single operation code.
  always_comb begin
    op_s = OP_HOLD;
    if (load) begin
      op_s = OP_LOAD;
    end else if (enable) begin
      op_s = OP_COUNT;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next register values; carry defaults low so it only pulses on a hit.
  always_comb begin
    count_d     = count_q;
    carry_d     = 1'b0;
    direction_d = direction_q;
    case (op_s)
      OP_LOAD: begin
        count_d = load_clamped_s;
      end
      OP_COUNT: begin
        count_d     = step_next_s;
        carry_d     = step_hit_s;
        direction_d = updown;
      end
      OP_HOLD: begin
        count_d = count_q;
      end
      default: begin
        count_d     = count_q;
        carry_d     = 1'b0;
        direction_d = direction_q;
      end
    endcase
  end

  // State registers; clear forces the idle state regardless of the clock.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count_q     <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      direction_q <= DIR_UP;
    end else begin
      count_q     <= count_d;
      carry_q     <= carry_d;
      direction_q <= direction_d;
    end
  end

  assign q     = count_q;
  assign carry = carry_q;
  assign dir_q = direction_q;

endmodule : updown_counter_n

// File: tb/tb_updown_counter_n.sv
// Directed self-checking bench for updown_counter_n at WIDTH=3, MODULUS=6.
// Expected values follow the saturating variant when COUNTER_SATURATE_EN
// is defined, the wrapping variant otherwise.
module tb_updown_counter_n;

  localparam int              WIDTH   = 3;
  localparam longint unsigned MODULUS = 6;

  logic             clock = 1'b0;
  logic             clear;
  logic             enable;
  logic             updown;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             dir_q;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  updown_counter_n #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .enable     (enable),
    .updown     (updown),
    .load       (load),
    .load_value (load_value),
    .q          (q),
    .carry      (carry),
    .dir_q      (dir_q)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0; enable = 1'b1; updown = 1'b0; load = 1'b0; load_value = 3'd0;
    repeat (2) tick();
    compared++;
    if (q !== 3'd0) begin
      $display("FAIL reset_q: got %0d want 0", q); mismatched++;
    end
    compared++;
    if (carry !== 1'b0) begin
      $display("FAIL reset_carry: got %b want 0", carry); mismatched++;
    end
    compared++;
    if (dir_q !== 1'b1) begin
      $display("FAIL reset_dir: got %b want 1", dir_q); mismatched++;
    end
  endtask

  task automatic test_count_up();
    int exp_q [7] = '{1, 2, 3, 4, 5, 0, 1};
    int exp_c [7] = '{0, 0, 0, 0, 0, 1, 0};
`ifdef COUNTER_SATURATE_EN
    exp_q = '{1, 2, 3, 4, 5, 5, 5};
    exp_c = '{0, 0, 0, 0, 0, 1, 1};
`endif
    clear = 1'b1; enable = 1'b1; updown = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      compared++;
      if (q !== 3'(exp_q[i])) begin
        $display("FAIL up_q[%0d]: got %0d want %0d", i, q, exp_q[i]); mismatched++;
      end
      compared++;
      if (carry !== 1'(exp_c[i])) begin
        $display("FAIL up_carry[%0d]: got %b want %0d", i, carry, exp_c[i]); mismatched++;
      end
      compared++;
      if (dir_q !== 1'b1) begin
        $display("FAIL up_dir[%0d]: got %b want 1", i, dir_q); mismatched++;
      end
    end
  endtask

  task automatic test_count_down();
    int exp_q [2] = '{5, 4};
    int exp_c [2] = '{1, 0};
`ifdef COUNTER_SATURATE_EN
    exp_q = '{0, 0};
    exp_c = '{1, 1};
`endif
    load = 1'b1; load_value = 3'd0;
    tick();
    compared++;
    if (q !== 3'd0 || carry !== 1'b0) begin
      $display("FAIL down_preload: got q=%0d c=%b want q=0 c=0", q, carry); mismatched++;
    end
    load = 1'b0; enable = 1'b1; updown = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++;
      if (q !== 3'(exp_q[i])) begin
        $display("FAIL down_q[%0d]: got %0d want %0d", i, q, exp_q[i]); mismatched++;
      end
      compared++;
      if (carry !== 1'(exp_c[i])) begin
        $display("FAIL down_carry[%0d]: got %b want %0d", i, carry, exp_c[i]); mismatched++;
      end
      compared++;
      if (dir_q !== 1'b0) begin
        $display("FAIL down_dir[%0d]: got %b want 0", i, dir_q); mismatched++;
      end
    end
  endtask

  task automatic test_load_clamp();
    int step_q = 0;
`ifdef COUNTER_SATURATE_EN
    step_q = 5;
`endif
    // Load wins over enable, clamps 7 to 5, clears carry and keeps dir_q=0.
    load = 1'b1; load_value = 3'd7; enable = 1'b1; updown = 1'b1;
    tick();
    compared++;
    if (q !== 3'd5 || carry !== 1'b0 || dir_q !== 1'b0) begin
      $display("FAIL load7: got q=%0d c=%b d=%b want q=5 c=0 d=0", q, carry, dir_q); mismatched++;
    end
    load = 1'b0;
    tick();
    compared++;
    if (q !== 3'(step_q) || carry !== 1'b1 || dir_q !== 1'b1) begin
      $display("FAIL load7_step: got q=%0d c=%b d=%b want q=%0d c=1 d=1", q, carry, dir_q, step_q); mismatched++;
    end
    load = 1'b1; load_value = 3'd6;
    tick();
    compared++;
    if (q !== 3'd5 || carry !== 1'b0) begin
      $display("FAIL load6: got q=%0d c=%b want q=5 c=0", q, carry); mismatched++;
    end
    load_value = 3'd4;
    tick();
    compared++;
    if (q !== 3'd4 || carry !== 1'b0) begin
      $display("FAIL load4: got q=%0d c=%b want q=4 c=0", q, carry); mismatched++;
    end
  endtask

  task automatic test_toggle();
    logic dirs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   exp_q [4] = '{4, 3, 4, 3};
    load = 1'b1; load_value = 3'd3;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      updown = dirs[i];
      tick();
      compared++;
      if (q !== 3'(exp_q[i]) || carry !== 1'b0) begin
        $display("FAIL toggle_q[%0d]: got q=%0d c=%b want q=%0d c=0", i, q, carry, exp_q[i]); mismatched++;
      end
      compared++;
      if (dir_q !== dirs[i]) begin
        $display("FAIL toggle_dir[%0d]: got %b want %b", i, dir_q, dirs[i]); mismatched++;
      end
    end
  endtask

  task automatic test_hold();
    load = 1'b1; load_value = 3'd1;
    tick();
    load = 1'b0; enable = 1'b1; updown = 1'b1;
    tick();
    enable = 1'b0; updown = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (q !== 3'd2 || carry !== 1'b0 || dir_q !== 1'b1) begin
        $display("FAIL hold[%0d]: got q=%0d c=%b d=%b want q=2 c=0 d=1", i, q, carry, dir_q); mismatched++;
      end
    end
  endtask

  task automatic test_clear_mid();
    int wrap_q = 5;
`ifdef COUNTER_SATURATE_EN
    wrap_q = 0;
`endif
    load = 1'b1; load_value = 3'd5;
    tick();
    load = 1'b0; enable = 1'b1; updown = 1'b0;
    tick();
    compared++;
    if (q !== 3'd4 || dir_q !== 1'b0) begin
      $display("FAIL preclear: got q=%0d d=%b want q=4 d=0", q, dir_q); mismatched++;
    end
    #2 clear = 1'b0;
    #1;
    compared++;
    if (q !== 3'd0 || carry !== 1'b0 || dir_q !== 1'b1) begin
      $display("FAIL async_clear: got q=%0d c=%b d=%b want q=0 c=0 d=1", q, carry, dir_q); mismatched++;
    end
    tick();
    compared++;
    if (q !== 3'd0 || dir_q !== 1'b1) begin
      $display("FAIL clear_held: got q=%0d d=%b want q=0 d=1", q, dir_q); mismatched++;
    end
    clear = 1'b1; enable = 1'b1; updown = 1'b0;
    tick();
    compared++;
    if (q !== 3'(wrap_q) || carry !== 1'b1 || dir_q !== 1'b0) begin
      $display("FAIL post_clear: got q=%0d c=%b d=%b want q=%0d c=1 d=0", q, carry, dir_q, wrap_q); mismatched++;
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_toggle();
    test_hold();
    test_clear_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_updown_counter_n
